// File: rtl/address_table_pkg.sv
// Shared types and constants for the address table arbiter.
package address_table_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int GROUP_BIT = 40;
  localparam int MAC_W     = 48;

endpackage

// File: rtl/address_table_arbiter_rr_arbiter.sv
// Round-robin selector: first asserted request at or above ptr_i, wrapping to 0.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PW-1:0]        ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [PW-1:0]        gnt_idx_o,
  output logic                 any_gnt_o
);

  logic [PW-1:0] cand_s;

  // Scan candidates in rotated priority order; the first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    cand_s    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand_s = PW'((int'(ptr_i) + i) % NUM_PORTS);
      if (req_i[cand_s] && !any_gnt_o) begin
        gnt_o[cand_s] = 1'b1;
        gnt_idx_o     = cand_s;
        any_gnt_o     = 1'b1;
      end else begin
        any_gnt_o = any_gnt_o;
      end
    end
  end

endmodule

// File: rtl/address_table_arbiter.sv
// Shares one MAC address table among NUM_PORTS ingress ports: grants one
// lookup at a time, issues learn/read, and returns a forwarding decision.
module address_table_arbiter
  import address_table_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PW        = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORTS-1:0]       req_valid_i,
  output logic [NUM_PORTS-1:0]       req_ready_o,
  input  logic [NUM_PORTS*MAC_W-1:0] req_src_mac_i,
  input  logic [NUM_PORTS*MAC_W-1:0] req_dst_mac_i,
  output logic [NUM_PORTS-1:0]       resp_valid_o,
  output logic [PW-1:0]              resp_port_o,
  output logic                       resp_flood_o,
  output logic                       resp_drop_o,
  output logic                       tbl_learn_req_o,
  output logic [MAC_W-1:0]           tbl_learn_address_o,
  output logic [PW-1:0]              tbl_learn_port_o,
  output logic                       tbl_read_req_o,
  output logic [MAC_W-1:0]           tbl_read_address_o,
  input  logic [PW-1:0]              tbl_read_port_i,
  input  logic                       tbl_read_valid_i
);

  arb_state_t state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        port_q, port_d;
  logic                 dst_group_q, dst_group_d;
  logic                 rd_req_q, rd_req_d;
  logic [MAC_W-1:0]     rd_addr_q, rd_addr_d;
  logic                 ln_req_q, ln_req_d;
  logic [MAC_W-1:0]     ln_addr_q, ln_addr_d;
  logic [PW-1:0]        ln_port_q, ln_port_d;
  logic [NUM_PORTS-1:0] resp_valid_q, resp_valid_d;
  logic [PW-1:0]        resp_port_q, resp_port_d;
  logic                 flood_q, flood_d;
  logic                 drop_q, drop_d;

  logic [NUM_PORTS-1:0] gnt_s;
  logic [PW-1:0]        gnt_idx_s;
  logic                 any_gnt_s;
  logic [MAC_W-1:0]     src_sel_s;
  logic [MAC_W-1:0]     dst_sel_s;
  logic                 flood_s;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_rr (
    .req_i     (req_valid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s),
    .any_gnt_o (any_gnt_s)
  );

  assign src_sel_s = req_src_mac_i[gnt_idx_s*MAC_W +: MAC_W];
  assign dst_sel_s = req_dst_mac_i[gnt_idx_s*MAC_W +: MAC_W];

  // Accept is combinational so the MACs are captured on the grant edge itself.
  assign req_ready_o = (state_q == IDLE && rst_n) ? gnt_s : {NUM_PORTS{1'b0}};

  // Next-state and registered-output computation; all strobes default low.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    port_d       = port_q;
    dst_group_d  = dst_group_q;
    rd_req_d     = 1'b0;
    rd_addr_d    = '0;
    ln_req_d     = 1'b0;
    ln_addr_d    = '0;
    ln_port_d    = '0;
    resp_valid_d = '0;
    resp_port_d  = '0;
    flood_d      = 1'b0;
    drop_d       = 1'b0;
    flood_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_gnt_s) begin
          state_d     = ISSUE;
          rr_ptr_d    = PW'((int'(gnt_idx_s) + 32'sd1) % NUM_PORTS);
          port_d      = gnt_idx_s;
          dst_group_d = dst_sel_s[GROUP_BIT];
          rd_req_d    = 1'b1;
          rd_addr_d   = dst_sel_s;
          // Group source addresses are never learned.
          if (!src_sel_s[GROUP_BIT]) begin
            ln_req_d  = 1'b1;
            ln_addr_d = src_sel_s;
            ln_port_d = gnt_idx_s;
          end else begin
            ln_req_d  = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d      = RESP;
        flood_s      = dst_group_q | ~tbl_read_valid_i;
        flood_d      = flood_s;
        drop_d       = ~flood_s & (tbl_read_port_i == port_q);
        resp_port_d  = flood_s ? port_q : tbl_read_port_i;
        resp_valid_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << port_q;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      port_q       <= '0;
      dst_group_q  <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      ln_req_q     <= 1'b0;
      ln_addr_q    <= '0;
      ln_port_q    <= '0;
      resp_valid_q <= '0;
      resp_port_q  <= '0;
      flood_q      <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      port_q       <= port_d;
      dst_group_q  <= dst_group_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      ln_req_q     <= ln_req_d;
      ln_addr_q    <= ln_addr_d;
      ln_port_q    <= ln_port_d;
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
      flood_q      <= flood_d;
      drop_q       <= drop_d;
    end
  end

  assign tbl_read_req_o      = rd_req_q;
  assign tbl_read_address_o  = rd_addr_q;
  assign tbl_learn_req_o     = ln_req_q;
  assign tbl_learn_address_o = ln_addr_q;
  assign tbl_learn_port_o    = ln_port_q;
  assign resp_valid_o        = resp_valid_q;
  assign resp_port_o         = resp_port_q;
  assign resp_flood_o        = flood_q;
  assign resp_drop_o         = drop_q;

endmodule

// File: tb/tb_address_table_arbiter.sv
// Self-checking bench: transaction-level model checked every cycle, plus
// directed transactions with hand-computed expectations.
module tb_address_table_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid_i = '0;
  logic [N-1:0]  req_ready_o;
  logic [N*48-1:0] req_src_mac_i = '0;
  logic [N*48-1:0] req_dst_mac_i = '0;
  logic [N-1:0]  resp_valid_o;
  logic [1:0]    resp_port_o;
  logic          resp_flood_o, resp_drop_o;
  logic          tbl_learn_req_o;
  logic [47:0]   tbl_learn_address_o;
  logic [1:0]    tbl_learn_port_o;
  logic          tbl_read_req_o;
  logic [47:0]   tbl_read_address_o;
  logic [1:0]    tbl_read_port_i = '0;
  logic          tbl_read_valid_i = 1'b0;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  address_table_arbiter #(.NUM_PORTS(N)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_src_mac_i       (req_src_mac_i),
    .req_dst_mac_i       (req_dst_mac_i),
    .resp_valid_o        (resp_valid_o),
    .resp_port_o         (resp_port_o),
    .resp_flood_o        (resp_flood_o),
    .resp_drop_o         (resp_drop_o),
    .tbl_learn_req_o     (tbl_learn_req_o),
    .tbl_learn_address_o (tbl_learn_address_o),
    .tbl_learn_port_o    (tbl_learn_port_o),
    .tbl_read_req_o      (tbl_read_req_o),
    .tbl_read_address_o  (tbl_read_address_o),
    .tbl_read_port_i     (tbl_read_port_i),
    .tbl_read_valid_i    (tbl_read_valid_i)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at cyc %0d", nm, cyc);
  endtask

  typedef struct {
    bit rd; logic [47:0] rd_a;
    bit ln; logic [47:0] ln_a; int ln_p;
    logic [3:0] rv; int rp; bit fl; bit dr;
  } exp_t;

  function automatic exp_t zero_exp();
    exp_t z;
    z.rd = 1'b0; z.rd_a = '0; z.ln = 1'b0; z.ln_a = '0; z.ln_p = 0;
    z.rv = '0; z.rp = 0; z.fl = 1'b0; z.dr = 1'b0;
    return z;
  endfunction

  exp_t exp_a[int];

  // Transaction model: a port is served every 4 cycles at most, round-robin,
  // table access the cycle after accept, response 3 cycles after accept.
  initial begin
    int rr, next_free, g, c, pend_c, pend_g;
    bit pend, fl;
    logic [47:0] src, pend_dst;
    logic [3:0] er;
    exp_t e, r;
    rr = 0; next_free = 0; pend = 1'b0; pend_c = 0; pend_g = 0; pend_dst = '0;
    forever begin
      @(negedge clk);
      er = '0;
      e  = zero_exp();
      if (!rst_n) begin
        rr = 0; next_free = 0; pend = 1'b0;
        exp_a.delete();
      end else begin
        if (pend && cyc == pend_c) begin
          r = zero_exp();
          fl = pend_dst[40] || !tbl_read_valid_i;
          r.rv = 4'b0001 << pend_g;
          r.fl = fl;
          r.rp = fl ? pend_g : int'(tbl_read_port_i);
          r.dr = !fl && (int'(tbl_read_port_i) == pend_g);
          exp_a[cyc+1] = r;
          pend = 1'b0;
        end
        if (cyc >= next_free && req_valid_i != '0) begin
          g = -1;
          for (int i = 0; i < N; i++) begin
            c = (rr + i) % N;
            if (g < 0 && req_valid_i[c]) g = c;
          end
          er = 4'b0001 << g;
          rr = (g + 1) % N;
          next_free = cyc + 4;
          r = zero_exp();
          src = req_src_mac_i[g*48 +: 48];
          r.rd = 1'b1;
          r.rd_a = req_dst_mac_i[g*48 +: 48];
          if (!src[40]) begin r.ln = 1'b1; r.ln_a = src; r.ln_p = g; end
          exp_a[cyc+1] = r;
          pend = 1'b1; pend_c = cyc + 2; pend_g = g; pend_dst = r.rd_a;
        end
        if (exp_a.exists(cyc)) begin e = exp_a[cyc]; exp_a.delete(cyc); end
      end
      chk("m_ready", req_ready_o, er);
      chk("m_rd_req", tbl_read_req_o, e.rd);
      chk("m_rd_addr", tbl_read_address_o, e.rd_a);
      chk("m_ln_req", tbl_learn_req_o, e.ln);
      chk("m_ln_addr", tbl_learn_address_o, e.ln_a);
      chk("m_ln_port", tbl_learn_port_o, e.ln_p);
      chk("m_resp_valid", resp_valid_o, e.rv);
      chk("m_resp_port", resp_port_o, e.rp);
      chk("m_flood", resp_flood_o, e.fl);
      chk("m_drop", resp_drop_o, e.dr);
    end
  end

  task automatic run_one(input int p, input logic [47:0] src, input logic [47:0] dst,
                         input logic hit, input logic [1:0] hp,
                         input logic [3:0] e_rv, input logic [1:0] e_rp,
                         input logic e_fl, input logic e_dr, input logic e_ln);
    int t;
    @(posedge clk); #1;
    req_src_mac_i[p*48 +: 48] = src;
    req_dst_mac_i[p*48 +: 48] = dst;
    tbl_read_valid_i = hit;
    tbl_read_port_i  = hp;
    req_valid_i[p]   = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready_o[p] && t < 20);
    if (!req_ready_o[p]) begin
      timeout("accept_wait");
      req_valid_i[p] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid_i[p] = 1'b0;
    @(negedge clk);
    chk("lit_rd_req", tbl_read_req_o, 1'b1);
    chk("lit_rd_addr", tbl_read_address_o, dst);
    chk("lit_learn_req", tbl_learn_req_o, e_ln);
    @(negedge clk);
    chk("lit_resp_early", resp_valid_o, 4'b0000);
    @(negedge clk);
    chk("lit_resp_valid", resp_valid_o, e_rv);
    chk("lit_resp_port", resp_port_o, e_rp);
    chk("lit_flood", resp_flood_o, e_fl);
    chk("lit_drop", resp_drop_o, e_dr);
    @(negedge clk);
    chk("lit_resp_single", resp_valid_o, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rr_seq [5];
    int t, last;
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;

    // Reset: requests present but nothing may be accepted or driven.
    req_valid_i = 4'b1111;
    #2;
    chk("rst_ready", req_ready_o, 4'b0000);
    chk("rst_rd_req", tbl_read_req_o, 1'b0);
    chk("rst_resp", resp_valid_o, 4'b0000);
    req_valid_i = 4'b0000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_one(1, 48'h00AA_BBCC_DD01, 48'h0011_2233_4455, 1'b1, 2'd2, 4'b0010, 2'd2, 1'b0, 1'b0, 1'b1);
    run_one(3, 48'h0000_0000_0003, 48'h0022_0000_0066, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
    run_one(1, 48'h0200_0000_0011, 48'h0200_0000_0022, 1'b1, 2'd1, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b1);
    run_one(2, 48'h0100_5E00_0001, 48'hFFFF_FFFF_FFFF, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    run_one(0, 48'h0000_0000_00A0, 48'h0000_0000_00B0, 1'b1, 2'd3, 4'b0001, 2'd3, 1'b0, 1'b0, 1'b1);

    // All ports requesting continuously from reset: 0,1,2,3,0 every 4 cycles.
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      req_src_mac_i[i*48 +: 48] = 48'h0000_0000_0010 + 48'(i);
      req_dst_mac_i[i*48 +: 48] = 48'h0000_0000_0020 + 48'(i);
    end
    tbl_read_valid_i = 1'b1;
    tbl_read_port_i  = 2'd0;
    req_valid_i = 4'b1111;
    rst_n = 1'b1;
    last = 0;
    for (int n = 0; n < 5; n++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (req_ready_o == 4'b0000 && t < 10);
      if (req_ready_o == 4'b0000) begin
        timeout("rr_wait");
      end else begin
        chk("rr_grant", req_ready_o, rr_seq[n]);
        if (n > 0) chk("rr_spacing", 64'(cyc - last), 64'd4);
        last = cyc;
      end
    end
    @(posedge clk); #1 req_valid_i = 4'b0000;
    repeat (6) @(negedge clk);

    // Reset during WAIT abandons the lookup and restarts priority at port 0.
    @(posedge clk); #1;
    req_src_mac_i[2*48 +: 48] = 48'h0000_0000_0042;
    req_dst_mac_i[2*48 +: 48] = 48'h0000_0000_0043;
    req_valid_i = 4'b0100;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready_o[2] && t < 20);
    if (!req_ready_o[2]) timeout("wait_rst_accept");
    @(posedge clk); #1 req_valid_i = 4'b0000;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("wrst_resp", resp_valid_o, 4'b0000);
    chk("wrst_rd_req", tbl_read_req_o, 1'b0);
    chk("wrst_ready", req_ready_o, 4'b0000);
    req_valid_i = 4'b1010;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("wrst_first_grant", req_ready_o, 4'b0010);
    @(posedge clk); #1 req_valid_i = 4'b0000;
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/address_table_arbiter.md
ADDRESS_TABLE_ARBITER -- requirements
Module: address_table_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of ingress ports sharing the address table; PW = $clog2(NUM_PORTS).
REQ-002 clk  input  1  single clock for the block, all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid_i  input  NUM_PORTS  per-port lookup request valid.
REQ-005 req_ready_o  output  NUM_PORTS  per-port request accept, one-hot or zero.
REQ-006 req_src_mac_i  input  NUM_PORTS x 48  per-port frame source MAC.
REQ-007 req_dst_mac_i  input  NUM_PORTS x 48  per-port frame destination MAC.
REQ-008 resp_valid_o  output  NUM_PORTS  per-port single-cycle response strobe, one-hot or zero.
REQ-009 resp_port_o  output  PW  egress port for the response.
REQ-010 resp_flood_o  output  1  forward to all ports except ingress.
REQ-011 resp_drop_o  output  1  discard frame (destination on ingress port).
REQ-012 tbl_learn_req_o  output  1; tbl_learn_address_o  output  48; tbl_learn_port_o  output  PW  table learn port.
REQ-013 tbl_read_req_o  output  1; tbl_read_address_o  output  48  table lookup port.
REQ-014 tbl_read_port_i  input  PW; tbl_read_valid_i  input  1  table lookup result, registered by the table one cycle after tbl_read_req_o.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, RESP; IDLE->ISSUE on grant, ISSUE->WAIT, WAIT->RESP, RESP->IDLE unconditionally.
REQ-016 In IDLE the block SHALL grant round-robin among asserted req_valid_i, searching from pointer rr_ptr upward with wrap to 0.
REQ-017 req_ready_o[g] SHALL be asserted combinationally in IDLE only for granted port g; src MAC, dst MAC and g are captured on that edge.
REQ-018 After each grant rr_ptr SHALL become (g+1) mod NUM_PORTS; no grant leaves rr_ptr unchanged.
REQ-019 No request SHALL be accepted in ISSUE, WAIT or RESP; held requests stay pending.
REQ-020 In ISSUE tbl_read_req_o SHALL pulse one cycle with tbl_read_address_o = captured dst MAC.
REQ-021 In ISSUE tbl_learn_req_o SHALL pulse with captured src MAC and port g, unless src MAC bit 40 (group bit) is 1, then no learn.
REQ-022 In WAIT the block SHALL sample tbl_read_valid_i/tbl_read_port_i as hit/hit_port.
REQ-023 In RESP resp_valid_o[g] SHALL pulse one cycle; flood = dst bit 40 set or !hit; drop = !flood and hit_port == g; resp_port_o = hit_port when !flood, else g.
REQ-024 Flood and drop SHALL be mutually exclusive; broadcast FF:FF:FF:FF:FF:FF always floods.
REQ-025 Outputs resp_*, tbl_*_req_o SHALL be 0 outside their active state; address/port buses SHALL be 0 when their strobe is low.
REQ-026 Throughput: one lookup per 4 cycles; request-to-response latency 3 cycles after the accept edge.

Reset
REQ-027 On rst_n low: state IDLE, rr_ptr 0, captured fields 0, all outputs 0, immediately and asynchronously.
REQ-028 Reset mid-transaction SHALL abandon it with no response; first grant after release goes to lowest-index valid port.

Structure
REQ-029 FSM enum type arb_state_t and GROUP_BIT = 40 SHALL live in address_table_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer in; one-hot grant, grant index, any-grant out).

Verification
REQ-031 Reset, single port 1 request, dst 00:11:22:33:44:55, table returns valid port 2 -> resp_valid_o=0010, resp_port_o=2, flood=0, drop=0, 3 cycles after accept.
REQ-032 All four ports valid continuously from reset -> grants in order 0,1,2,3,0, one every 4 cycles.
REQ-033 Dst miss (tbl_read_valid_i=0) on port 3 -> resp_flood_o=1, resp_port_o=3.
REQ-034 Hit with tbl_read_port_i equal to ingress port 1 -> resp_drop_o=1, resp_flood_o=0.
REQ-035 Src MAC 01:00:5E:00:00:01 -> tbl_learn_req_o stays 0, tbl_read_req_o still pulses; dst broadcast -> flood regardless of hit.
REQ-036 rst_n asserted during WAIT -> no resp_valid_o, all outputs 0, rr_ptr 0 after release.
